serial_adder: RTL and testbench

Parametrised bit-serial adder/subtractor: loads two WIDTH-bit operands on a start handshake, then resolves one bit per clock, LSB first, through a single full-adder cell and a registered carry. It reports sum, carry-out and signed overflow with a one-cycle done pulse. It is the area-minimal arithmetic unit for the lab datapath and replaces the purely combinational adder cells wherever throughput of one result per WIDTH+1 cycles is acceptable.

---
 rtl/serial_adder_pkg.sv | 18 +
 rtl/serial_adder_fa.sv | 13 +
 rtl/serial_adder.sv | 95 +++++++++
 tb/tb_serial_adder.sv | 200 ++++++++++++++++++++
 4 files changed

// File: rtl/serial_adder_pkg.sv
// Shared definitions for the bit-serial adder/subtractor: FSM states,
// width limits and the bit-counter sizing helper.
package serial_adder_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    localparam int MAX_WIDTH = 32;

    // Counter only needs to reach WIDTH-1; keep at least one bit.
    function automatic int cnt_w(input int width);
        return (width <= 2) ? 1 : $clog2(width);
    endfunction

endpackage

// File: rtl/serial_adder_fa.sv
// Single-bit full adder cell: the only arithmetic in the serial adder.
module fa (
    input  logic a,
    input  logic b,
    input  logic c_in,
    output logic s,
    output logic c_out
);

    assign s     = a ^ b ^ c_in;
    assign c_out = (a & b) | (c_in & (a ^ b));

endmodule

// File: rtl/serial_adder.sv
// Bit-serial adder/subtractor: one operand bit per clock, LSB first, through
// one full-adder cell and a registered carry.
module serial_adder
    import serial_adder_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             sub,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             c_in,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             c_out,
    output logic             ovf
);

    localparam int             CW   = cnt_w(WIDTH);
    localparam logic [CW-1:0]  LAST = CW'(WIDTH - 1);

    state_t           state, state_next;
    logic [WIDTH-1:0] op_a, op_b, res;
    logic [CW-1:0]    cnt;
    logic             carry;
    logic             fa_s, fa_co;
    logic             load, last_bit;

    assign load     = start && (state == IDLE || state == DONE);
    assign last_bit = (state == SHIFT) && (cnt == LAST);

    fa u_fa (
        .a     (op_a[0]),
        .b     (op_b[0]),
        .c_in  (carry),
        .s     (fa_s),
        .c_out (fa_co)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (start) state_next = SHIFT;
            SHIFT:   if (cnt == LAST) state_next = DONE;
            DONE:    state_next = start ? SHIFT : IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            op_a  <= '0;
            op_b  <= '0;
            res   <= '0;
            cnt   <= '0;
            carry <= 1'b0;
            busy  <= 1'b0;
            done  <= 1'b0;
            sum   <= '0;
            c_out <= 1'b0;
            ovf   <= 1'b0;
        end else begin
            busy <= (state_next == SHIFT);
            done <= (state_next == DONE);
            if (load) begin
                // Subtract as a + ~b + 1: invert B and force the carry-in.
                op_a  <= a;
                op_b  <= sub ? ~b : b;
                carry <= sub ? 1'b1 : c_in;
                cnt   <= '0;
            end else if (state == SHIFT) begin
                op_a  <= op_a >> 1;
                op_b  <= op_b >> 1;
                res   <= {fa_s, res[WIDTH-1:1]};
                carry <= fa_co;
                cnt   <= cnt + 1'b1;
                if (last_bit) begin
                    // Carry register still holds the carry into the MSB here.
                    sum   <= {fa_s, res[WIDTH-1:1]};
                    c_out <= fa_co;
                    ovf   <= carry ^ fa_co;
                end
            end
        end
    end

endmodule

// File: tb/tb_serial_adder.sv
// Randomised and directed bench for serial_adder (WIDTH=8) against a
// cycle-scheduled arithmetic reference model.
module tb_serial_adder;

    localparam int W = 8;

    logic         clk = 1'b0;
    logic         rst_n = 1'b1;
    logic         start = 1'b0;
    logic         sub = 1'b0;
    logic [W-1:0] a = '0;
    logic [W-1:0] b = '0;
    logic         c_in = 1'b0;
    logic         busy, done, c_out, ovf;
    logic [W-1:0] sum;

    int vectors = 0;
    int miscompares = 0;

    serial_adder #(.WIDTH(W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start),
        .sub   (sub),
        .a     (a),
        .b     (b),
        .c_in  (c_in),
        .busy  (busy),
        .done  (done),
        .sum   (sum),
        .c_out (c_out),
        .ovf   (ovf)
    );

    always #5 clk = ~clk;

    // Reference arithmetic from plain integer rules.
    task automatic ref_op(input logic [W-1:0] xa, input logic [W-1:0] xb,
                          input logic xs, input logic xc,
                          output logic [W-1:0] r, output logic co, output logic v);
        logic [W:0] t;
        if (xs) begin
            t  = {1'b0, xa} - {1'b0, xb};
            r  = t[W-1:0];
            co = (xa >= xb);
            v  = (xa[W-1] != xb[W-1]) && (r[W-1] != xa[W-1]);
        end else begin
            t  = {1'b0, xa} + {1'b0, xb} + {{W{1'b0}}, xc};
            r  = t[W-1:0];
            co = t[W];
            v  = (xa[W-1] == xb[W-1]) && (r[W-1] != xa[W-1]);
        end
    endtask

    // Model: an accepted request completes W edges later.
    int           rem = 0;
    logic         busy_e = 0, done_e = 0, cout_e = 0, ovf_e = 0, p_c = 0, p_v = 0;
    logic [W-1:0] sum_e = '0, p_sum = '0;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rem = 0; busy_e = 0; done_e = 0; sum_e = '0; cout_e = 0; ovf_e = 0;
        end else if (rem != 0) begin
            rem    = rem - 1;
            busy_e = (rem != 0);
            done_e = (rem == 0);
            if (rem == 0) begin
                sum_e = p_sum; cout_e = p_c; ovf_e = p_v;
            end
        end else begin
            done_e = 0;
            busy_e = 0;
            if (start) begin
                ref_op(a, b, sub, c_in, p_sum, p_c, p_v);
                rem    = W;
                busy_e = 1;
            end
        end
    end

    always @(negedge clk) begin
        vectors++;
        if ({busy, done, sum, c_out, ovf} !== {busy_e, done_e, sum_e, cout_e, ovf_e}) begin
            miscompares++;
            $display("FAIL model t=%0t got busy=%b done=%b sum=%h c=%b v=%b exp busy=%b done=%b sum=%h c=%b v=%b",
                     $time, busy, done, sum, c_out, ovf, busy_e, done_e, sum_e, cout_e, ovf_e);
        end
    end

    task automatic chk(input string name, input logic [W+3:0] got, input logic [W+3:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s got=%h exp=%h", name, got, exp);
        end
    endtask

    task automatic launch(input logic [W-1:0] xa, input logic [W-1:0] xb,
                          input logic xs, input logic xc);
        @(negedge clk);
        a = xa; b = xb; sub = xs; c_in = xc; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        a = W'($urandom); b = W'($urandom); sub = 1'($urandom); c_in = 1'($urandom);
    endtask

    // Waits for done, toggling start randomly while busy; lat = negedges waited.
    task automatic wait_done(output int lat);
        lat = 0;
        while (done !== 1'b1 && lat < 40) begin
            if (busy === 1'b1) start = 1'($urandom);
            @(negedge clk);
            lat++;
        end
        start = 1'b0;
        if (done !== 1'b1) chk("done_timeout", {3'b0, done, 8'h00}, 12'h100);
    endtask

    task automatic op_lit(input string name, input logic [W-1:0] xa, input logic [W-1:0] xb,
                          input logic xs, input logic xc,
                          input logic [W-1:0] es, input logic ec, input logic ev);
        int lat;
        launch(xa, xb, xs, xc);
        wait_done(lat);
        chk(name, {2'b0, c_out, ovf, sum}, {2'b0, ec, ev, es});
    endtask

    initial begin
        int lat, last_t, pulses;
        logic [W-1:0] ra, rb;

        #1 rst_n = 1'b0;
        #1 chk("reset_outputs", {busy, done, c_out, ovf, sum}, '0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        // Latency: drive at one negedge, done visible W+1 negedges later.
        launch(8'h0F, 8'h01, 1'b0, 1'b0);
        wait_done(lat);
        chk("latency", 12'(lat + 1), 12'(W + 1));
        chk("add_0F_01", {2'b0, c_out, ovf, sum}, {2'b0, 1'b0, 1'b0, 8'h10});

        op_lit("add_FF_01_c1", 8'hFF, 8'h01, 1'b0, 1'b1, 8'h01, 1'b1, 1'b0);
        op_lit("sub_05_07",    8'h05, 8'h07, 1'b1, 1'b0, 8'hFE, 1'b0, 1'b0);
        op_lit("sub_80_01",    8'h80, 8'h01, 1'b1, 1'b0, 8'h7F, 1'b1, 1'b1);
        op_lit("add_7F_01",    8'h7F, 8'h01, 1'b0, 1'b0, 8'h80, 1'b0, 1'b1);
        op_lit("sub_ignore_cin", 8'h10, 8'h10, 1'b1, 1'b1, 8'h00, 1'b1, 1'b0);

        // Start pulse during SHIFT must be ignored.
        launch(8'h12, 8'h34, 1'b0, 1'b0);
        @(negedge clk);
        a = 8'hAA; b = 8'hAA; sub = 1'b1; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_done(lat);
        chk("start_in_shift", {2'b0, c_out, ovf, sum}, {2'b0, 1'b0, 1'b0, 8'h46});
        repeat (2) @(negedge clk);

        // Start held high: done every W+1 cycles.
        @(negedge clk);
        a = 8'h21; b = 8'h13; sub = 1'b0; c_in = 1'b0; start = 1'b1;
        last_t = -1; pulses = 0;
        for (int i = 0; i < 4 * (W + 1) + 2; i++) begin
            @(negedge clk);
            if (done === 1'b1) begin
                if (last_t >= 0) chk("b2b_period", 12'(i - last_t), 12'(W + 1));
                last_t = i;
                pulses++;
                chk("b2b_sum", {4'b0, sum}, 12'h034);
            end
        end
        chk("b2b_pulses", 12'(pulses), 12'd4);
        start = 1'b0;
        repeat (W + 3) @(negedge clk);

        // Reset during SHIFT aborts the operation.
        launch(8'h55, 8'h22, 1'b0, 1'b0);
        repeat (3) @(negedge clk);
        #2 rst_n = 1'b0;
        #1 chk("reset_mid_shift", {busy, done, c_out, ovf, sum}, '0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (W + 2) @(negedge clk);
        op_lit("after_reset_03_04", 8'h03, 8'h04, 1'b0, 1'b0, 8'h07, 1'b0, 1'b0);

        // Random operations, arbitrary gaps, start noise while busy.
        for (int n = 0; n < 60; n++) begin
            ra = W'($urandom); rb = W'($urandom);
            repeat ($urandom_range(0, 2)) @(negedge clk);
            launch(ra, rb, 1'($urandom), 1'($urandom));
            wait_done(lat);
        end

        repeat (3) @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
